// File: rtl/csa_acc_pkg.sv
// Shared types and sizing helpers for the carry-save stream accumulator.
package csa_acc_pkg;

  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

  // Result width: enough headroom for M operands of n bits.
  function automatic int calc_w(input int n, input int m);
    return n + $clog2(m);
  endfunction

  // Number of chunk cycles needed to resolve a w-bit redundant pair.
  function automatic int calc_r(input int w, input int chunk);
    return (w + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/csa_compress32.sv
// Combinational W-bit 3:2 compressor; carry is returned pre-shifted by one.
module csa_compress32
  import csa_acc_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] x,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ x;
  assign maj   = (a & b) | (a & x) | (b & x);
  assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Sequential multi-operand adder: carry-save accumulate, then chunked resolve.
// Optional: define CSA_ACC_SIGNED_EN for two's complement operands and result.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int CHUNK = 4,
  localparam int W    = calc_w(N, M),
  localparam int CW   = $clog2(M) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic [CW-1:0] out_count
);

  localparam int R  = calc_r(W, CHUNK);
  localparam int RW = R * CHUNK;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  state_t         state;
  logic [W-1:0]   s, c, x, s_nxt, c_nxt;
  logic [CW-1:0]  count;
  logic           cin;
  logic [IW-1:0]  idx;
  logic [W-1:0]   res;
  logic [RW-1:0]  s_pad, c_pad;
  logic [CHUNK:0] csum;

`ifdef CSA_ACC_SIGNED_EN
  assign x = {{(W-N){in_data[N-1]}}, in_data};
`else
  assign x = {{(W-N){1'b0}}, in_data};
`endif

  csa_compress32 #(.W(W)) u_cmp (
    .a     (s),
    .b     (c),
    .x     (x),
    .sum   (s_nxt),
    .carry (c_nxt)
  );

  // Pad the redundant pair so the last, possibly partial, chunk slices cleanly.
  assign s_pad = RW'(s);
  assign c_pad = RW'(c);
  assign csum  = {1'b0, s_pad[idx*CHUNK +: CHUNK]} + {1'b0, c_pad[idx*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      s         <= '0;
      c         <= '0;
      count     <= '0;
      cin       <= 1'b0;
      idx       <= '0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid && in_ready) begin
            s     <= s_nxt;
            c     <= c_nxt;
            count <= count + CW'(1);
            if (in_last || count == CW'(M - 1)) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          // Only bits below W are kept; the final carry-out falls off the top.
          for (int j = 0; j < W; j++)
            if (j / CHUNK == int'(idx)) res[j] <= csum[j % CHUNK];
          cin <= csum[CHUNK];
          if (idx == IW'(R - 1)) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            s         <= '0;
            c         <= '0;
            count     <= '0;
            cin       <= 1'b0;
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign out_sum   = res;
  assign out_count = count;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator with a cycle-level reference model.
module tb_csa_accumulator;

  localparam int N     = 4;
  localparam int M     = 8;
  localparam int CHUNK = 4;
  localparam int W     = N + $clog2(M);
  localparam int CW    = $clog2(M) + 1;
  localparam int R     = (W + CHUNK - 1) / CHUNK;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  csa_accumulator #(.N(N), .M(M), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ext(input logic [N-1:0] d);
`ifdef CSA_ACC_SIGNED_EN
    return int'($signed(d));
`else
    return int'(d);
`endif
  endfunction

  // Reference model: running integer sum, operand count, and handshake timing.
  int m_acc = 0, m_cnt = 0, m_pend = 0;
  bit m_ready = 1'b1, m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= 0; m_cnt <= 0; m_pend <= 0; m_ready <= 1'b1; m_valid <= 1'b0;
    end else if (m_ready && in_valid) begin
      m_acc <= m_acc + ext(in_data);
      m_cnt <= m_cnt + 1;
      if (in_last || m_cnt + 1 == M) begin
        m_ready <= 1'b0;
        m_pend  <= R;
      end
    end else if (m_pend != 0) begin
      m_pend <= m_pend - 1;
      if (m_pend == 1) m_valid <= 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0; m_ready <= 1'b1; m_acc <= 0; m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_in_ready", 32'(in_ready), 32'(m_ready));
      check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("cmp_out_sum", 32'(out_sum), 32'(m_acc[W-1:0]));
        check("cmp_out_count", 32'(out_count), 32'(m_cnt));
      end
    end
  end

  task automatic send(input logic [N-1:0] d, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called one step after the accept edge of the last operand.
  task automatic expect_result(input int lat, input int sum, input int cnt, input string name);
    int k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check({name, "_latency"}, 32'(k), 32'(lat));
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_sum"}, 32'(out_sum), 32'(sum));
    check({name, "_count"}, 32'(out_count), 32'(cnt));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;

    // Eight operands of 15, last on the eighth.
    for (int i = 0; i < 8; i++) send(4'd15, i == 7);
    expect_result(2, 120, 8, "max8");
    @(posedge clk); #1;
    check("max8_ready_back", 32'(in_ready), 32'd1);
    check("max8_valid_drop", 32'(out_valid), 32'd0);

    // 3, 5, 7.
    send(4'd3, 1'b0); send(4'd5, 1'b0); send(4'd7, 1'b1);
    check("s357_busy", 32'(in_ready), 32'd0);
    expect_result(2, 15, 3, "s357");
    @(posedge clk); #1;
    check("s357_ready_back", 32'(in_ready), 32'd1);

    // Single operand.
    send(4'd9, 1'b1);
    expect_result(2, 9, 1, "single");
    @(posedge clk); #1;

    // 1..8 without last; a ninth word waits while the result is stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    in_valid = 1'b1; in_data = 4'd5; in_last = 1'b1;
    expect_result(2, 36, 8, "forced");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(out_sum), 32'd36);
      check("stall_held_off", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(4'd5, 1'b1);
    expect_result(2, 5, 1, "ninth");
    @(posedge clk); #1;

    // Reset during resolve of 6, 6, 6.
    send(4'd6, 1'b0); send(4'd6, 1'b0); send(4'd6, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    check("abort_out_count", 32'(out_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(4'd1, 1'b0); send(4'd2, 1'b1);
    expect_result(2, 3, 2, "after_abort");
    @(posedge clk); #1;

    // Bit patterns -8, 7, -1 as 4-bit words.
    send(4'h8, 1'b0); send(4'h7, 1'b0); send(4'hF, 1'b1);
`ifdef CSA_ACC_SIGNED_EN
    expect_result(2, 32'h7E, 3, "signed_mix");
`else
    expect_result(2, 30, 3, "unsigned_mix");
`endif
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
